// File: rtl/ex_mem_dbus_stage_pkg.sv
// Shared types for the EX->MEM register: pipeline entry, data-bus request/response
// and the bus-transaction state of the latched entry.
package ex_mem_dbus_stage_pkg;

  typedef logic [63:0] u64;
  typedef logic [2:0]  msize_t;

  localparam msize_t MSIZE8 = 3'd3;

  typedef struct packed {
    logic       valid;
    u64         pc;
    u64         aluout;
    u64         writedata;
    logic       memtoreg;
    logic       memwrite;
    logic       regwrite;
    logic [4:0] dst;
  } execute_data_t;

  typedef struct packed {
    logic       valid;
    u64         addr;
    msize_t     size;
    logic [7:0] strobe;
    u64         data;
  } dbus_req_t;

  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    u64   data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } mem_state_t;

  function automatic logic need_mem(input execute_data_t x);
    return x.valid & (x.memtoreg | x.memwrite);
  endfunction

endpackage

// File: rtl/ex_mem_dbus_stage_if.sv
// Data-bus port bundle: the core side is master (drives req), memory side is slave.
interface ex_mem_dbus_stage_if;
  import ex_mem_dbus_stage_pkg::*;

  dbus_req_t  req;
  dbus_resp_t resp;

  modport master (output req, input  resp);
  modport slave  (input  req, output resp);
endinterface

// File: rtl/ex_mem_dbus_stage.sv
// EX->MEM pipeline register that owns the data-bus transaction of its latched entry
// and freezes upstream stages until the bus returns data_ok.
module ex_mem_dbus_stage
  import ex_mem_dbus_stage_pkg::*;
#(
  parameter int WAITCNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  execute_data_t        i_dataE_in,
  input  logic                 i_stall,
  input  logic                 i_flush,
  output execute_data_t        o_dataE_out,
  output u64                   o_readdata,
  ex_mem_dbus_stage_if.master  dbus,
  output logic                 o_mem_stall,
  output logic [WAITCNT_W-1:0] o_wait_cnt
);

  execute_data_t        r_entry;
  u64                   r_rdata;
  mem_state_t           r_state;
  mem_state_t           w_state_nxt;
  logic [WAITCNT_W-1:0] r_wait_cnt;
  execute_data_t        w_next_entry;
  logic                 w_waiting;
  logic                 w_data_ok;
  logic                 w_mem_stall;
  logic                 w_adv;

  assign w_waiting    = (r_state == S_WAIT);
  assign w_data_ok    = dbus.resp.data_ok;
  assign w_mem_stall  = w_waiting & ~w_data_ok;
  assign w_adv        = ~w_mem_stall & ~i_stall;
  assign w_next_entry = i_flush ? '0 : i_dataE_in;

  // Next transaction state; data_ok under an external stall parks in S_DONE so no re-issue
  always_comb begin
    w_state_nxt = r_state;
    if (w_adv) begin
      w_state_nxt = need_mem(w_next_entry) ? S_WAIT : S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_IDLE;
        S_WAIT:  w_state_nxt = w_data_ok ? S_DONE : S_WAIT;
        S_DONE:  w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State register, latched entry, captured load data and wait counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_entry    <= '0;
      r_rdata    <= 64'd0;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_adv) begin
        r_entry <= w_next_entry;
      end
      if (w_waiting && w_data_ok) begin
        r_rdata <= dbus.resp.data;
      end
      if (w_mem_stall && (r_wait_cnt != {WAITCNT_W{1'b1}})) begin
        r_wait_cnt <= r_wait_cnt + {{(WAITCNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Request fields come straight from the latched entry, so they cannot move mid-transaction
  always_comb begin
    dbus.req.valid  = w_waiting;
    dbus.req.addr   = r_entry.aluout;
    dbus.req.size   = MSIZE8;
    dbus.req.strobe = r_entry.memwrite ? 8'hFF : 8'h00;
    dbus.req.data   = r_entry.writedata;
  end

  assign o_dataE_out = r_entry;
  assign o_readdata  = w_waiting ? dbus.resp.data : r_rdata;
  assign o_mem_stall = w_mem_stall;
  assign o_wait_cnt  = r_wait_cnt;

endmodule
